// File: rtl/uart_pkg.sv
// Shared definitions for the DIF UART sender and receiver: line defaults,
// state encoding and the clocks-per-bit computation.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ_DEF = 40_000_000;
  localparam int unsigned UART_BAUD_DEF     = 38_400;

  localparam int unsigned UART_ST_W = 3;
  typedef logic [UART_ST_W-1:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Clocks per line bit; integer division, the residue is absorbed as baud error.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last
// clock of each line bit with a one-cycle bit_end pulse.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = baud_div(UART_CLK_FREQ_DEF, UART_BAUD_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : g_div_check
    $error("uart_baud_tick: BAUD_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;

  assign bit_end = en && (cnt_q == CNT_LAST);

  // Bit-period counter; wraps on each bit boundary, held at zero when cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (bit_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_byte_sender.sv
// UART byte sender for the DIF serial link: start(0), data LSB first,
// optional even parity, 1 or 2 stop bits. A one-deep holding register is
// refilled while a frame is on the wire so frames can run back to back.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | line idle high, waiting for the holding register to fill
//   ST_START  | start bit (0) on the line
//   ST_DATA   | data bits, LSB first, bit_cnt_q selects the position
//   ST_PARITY | parity bit (XOR of the data latched at frame start)
//   ST_STOP   | stop bit(s); last clock pulses done and may chain to START
module uart_byte_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = UART_CLK_FREQ_DEF,
  parameter int unsigned BAUD         = UART_BAUD_DEF,
  parameter int unsigned DATA_BIT_NUM = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BIT_NUM-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BIT_W    = (DATA_BIT_NUM > 1) ? $clog2(DATA_BIT_NUM) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BIT_NUM - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_byte_sender: STOP_BITS must be 1 or 2");
  end

  uart_state_t state_q, state_d;

  logic                    hold_full_q;
  logic [DATA_BIT_NUM-1:0] hold_data_q;
  logic [DATA_BIT_NUM-1:0] shift_q, shift_d;
  logic                    parity_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic                    stop_cnt_q;
  logic                    tx_q, tx_d;

  logic accept;
  logic frame_start;
  logic stop_last;
  logic bit_end;
  logic baud_en;
  logic baud_clr;

  assign accept      = din_valid && !hold_full_q;
  assign din_ready   = !hold_full_q;
  assign stop_last   = (stop_cnt_q == STOP_LAST);
  // A frame starts whenever START is entered from outside START.
  assign frame_start = (state_d == ST_START) && (state_q != ST_START);
  assign baud_en     = (state_q != ST_IDLE);
  assign baud_clr    = (state_q == ST_IDLE) || frame_start;
  assign tx          = tx_q;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .en      (baud_en),
    .bit_end (bit_end)
  );

  // State register and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state decode; every transition except IDLE->START waits for a bit boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt_q == BIT_LAST)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && stop_last) begin
          state_d = hold_full_q ? ST_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shifter next value: load at frame start, step one bit per DATA boundary.
  always_comb begin
    shift_d = shift_q;
    if (frame_start) begin
      shift_d = hold_data_q;
    end else if ((state_q == ST_DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end
  end

  // Outputs: next line level from the upcoming state, plus status flags.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_STOP) && bit_end && stop_last;
  end

  // Holding register, shifter, parity and bit/stop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
    end else begin
      // din_ready is low while full, so accept and frame_start never coincide.
      if (accept) begin
        hold_full_q <= 1'b1;
        hold_data_q <= din;
      end else if (frame_start) begin
        hold_full_q <= 1'b0;
      end

      shift_q <= shift_d;

      if (frame_start) begin
        parity_q   <= ^hold_data_q;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
      end else begin
        if ((state_q == ST_DATA) && bit_end) bit_cnt_q <= bit_cnt_q + 1'b1;
        if ((state_q == ST_STOP) && bit_end) stop_cnt_q <= stop_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_sender.sv
`timescale 1ns/1ps
// Directed bench for uart_byte_sender: three instances (short bit period with
// parity, short bit period without parity and two stops, default 1041 clocks).
module tb_uart_byte_sender;

  localparam int DIV       = 10;
  localparam int FRAME     = 11 * DIV;
  localparam int DIV_DEF   = 1041;
  localparam int FRAME_DEF = 11451;
  localparam int CAP_MAX   = 11460;
  localparam int TMO       = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_w [3];
  logic [2:0] valid_v;
  wire  [2:0] ready_v, tx_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;

  logic cap_tx   [CAP_MAX];
  logic cap_busy [CAP_MAX];
  logic cap_done [CAP_MAX];
  logic cap_rdy  [CAP_MAX];
  logic cap_acc  [CAP_MAX];

  always #5 clk = ~clk;

  uart_byte_sender #(.CLK_FREQ(40_000_000), .BAUD(4_000_000), .DATA_BIT_NUM(8),
                     .PARITY_EN(1), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .din(din_w[0]), .din_valid(valid_v[0]),
    .din_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_byte_sender #(.CLK_FREQ(40_000_000), .BAUD(4_000_000), .DATA_BIT_NUM(8),
                     .PARITY_EN(0), .STOP_BITS(2)) u_dut_np2 (
    .clk(clk), .rst(rst), .din(din_w[1]), .din_valid(valid_v[1]),
    .din_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_byte_sender u_dut_def (
    .clk(clk), .rst(rst), .din(din_w[2]), .din_valid(valid_v[2]),
    .din_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Offer one byte and drop valid right after the accepting edge.
  task automatic send_byte(input int which, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    din_w[which]   = b;
    valid_v[which] = 1'b1;
    while (ready_v[which] !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ready_v[which] !== 1'b1) begin
      $display("FAIL send_accept_timeout inst=%0d byte=%h ready=%b exp=1", which, b, ready_v[which]);
      failures++;
    end
    @(posedge clk);
    #1;
    valid_v[which] = 1'b0;
  endtask

  // Wait for the start bit, then record one sample per clock (index 0 = first start clock).
  task automatic capture(input int which, input int ncyc, output bit ok);
    int t = 0;
    ok = 1'b1;
    @(negedge clk);
    while (tx_v[which] !== 1'b0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (tx_v[which] !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      cap_tx[i]   = tx_v[which];
      cap_busy[i] = busy_v[which];
      cap_done[i] = done_v[which];
      cap_rdy[i]  = ready_v[which];
      cap_acc[i]  = valid_v[which] & ready_v[which];
    end
  endtask

  function automatic int bad_cycles(input int base, input int len, input logic val);
    int n = 0;
    for (int i = 0; i < len; i++) if (cap_tx[base + i] !== val) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode_at(input int base);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = cap_tx[base + (1 + j) * DIV + DIV / 2];
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_v[0] !== 1'b1)    begin $display("FAIL rst_tx got=%b exp=1", tx_v[0]); failures++; end
    checks++; if (ready_v[0] !== 1'b1) begin $display("FAIL rst_ready got=%b exp=1", ready_v[0]); failures++; end
    checks++; if (busy_v[0] !== 1'b0)  begin $display("FAIL rst_busy got=%b exp=0", busy_v[0]); failures++; end
    checks++; if (done_v[0] !== 1'b0)  begin $display("FAIL rst_done got=%b exp=0", done_v[0]); failures++; end
    checks++; if (tx_v[2] !== 1'b1)    begin $display("FAIL rst_tx_def got=%b exp=1", tx_v[2]); failures++; end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    bit ok;
    int n;
    int dcnt = 0;
    logic [10:0] exp_f;
    exp_f = 11'b1_0_10100101_0;
    send_byte(2, 8'hA5);
    checks++; if (ready_v[2] !== 1'b0) begin $display("FAIL t1_ready_held got=%b exp=0", ready_v[2]); failures++; end
    checks++; if (tx_v[2] !== 1'b1)    begin $display("FAIL t1_tx_before_start got=%b exp=1", tx_v[2]); failures++; end
    @(posedge clk);
    #1;
    checks++; if (tx_v[2] !== 1'b0)    begin $display("FAIL t1_tx_start got=%b exp=0", tx_v[2]); failures++; end
    checks++; if (ready_v[2] !== 1'b1) begin $display("FAIL t1_ready_freed got=%b exp=1", ready_v[2]); failures++; end
    checks++; if (busy_v[2] !== 1'b1)  begin $display("FAIL t1_busy got=%b exp=1", busy_v[2]); failures++; end
    capture(2, FRAME_DEF + 2, ok);
    checks++; if (!ok) begin $display("FAIL t1_capture_timeout got=0 exp=1"); failures++; end
    for (int k = 0; k < 11; k++) begin
      n = bad_cycles(k * DIV_DEF, DIV_DEF, exp_f[k]);
      checks++;
      if (n !== 0) begin $display("FAIL t1_bit%0d bad_cycles=%0d exp=0 level=%b", k, n, exp_f[k]); failures++; end
    end
    for (int i = 0; i < FRAME_DEF + 2; i++) if (cap_done[i] === 1'b1) dcnt++;
    checks++; if (cap_done[FRAME_DEF-1] !== 1'b1) begin $display("FAIL t1_done_last got=%b exp=1", cap_done[FRAME_DEF-1]); failures++; end
    checks++; if (dcnt !== 1) begin $display("FAIL t1_done_count got=%0d exp=1", dcnt); failures++; end
    checks++; if (cap_busy[FRAME_DEF-1] !== 1'b1) begin $display("FAIL t1_busy_last got=%b exp=1", cap_busy[FRAME_DEF-1]); failures++; end
    checks++; if (cap_busy[FRAME_DEF] !== 1'b0)   begin $display("FAIL t1_busy_after got=%b exp=0", cap_busy[FRAME_DEF]); failures++; end
    checks++; if (cap_tx[FRAME_DEF] !== 1'b1)     begin $display("FAIL t1_tx_after got=%b exp=1", cap_tx[FRAME_DEF]); failures++; end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [10:0] exp_a, exp_b;
    exp_a = 11'b1_1_00000001_0;
    exp_b = 11'b1_0_11111111_0;
    fork
      capture(0, 2 * FRAME + 2, ok);
      begin
        send_byte(0, 8'h01);
        repeat (20) @(posedge clk);
        send_byte(0, 8'hFF);
      end
    join
    checks++; if (!ok) begin $display("FAIL t2_capture_timeout got=0 exp=1"); failures++; end
    for (int k = 0; k < 11; k++) begin
      n = bad_cycles(k * DIV, DIV, exp_a[k]);
      checks++;
      if (n !== 0) begin $display("FAIL t2_f1_bit%0d bad_cycles=%0d exp=0", k, n); failures++; end
      n = bad_cycles(FRAME + k * DIV, DIV, exp_b[k]);
      checks++;
      if (n !== 0) begin $display("FAIL t2_f2_bit%0d bad_cycles=%0d exp=0", k, n); failures++; end
    end
    checks++; if (cap_done[FRAME-1] !== 1'b1)   begin $display("FAIL t2_done1 got=%b exp=1", cap_done[FRAME-1]); failures++; end
    checks++; if (cap_done[2*FRAME-1] !== 1'b1) begin $display("FAIL t2_done2 got=%b exp=1", cap_done[2*FRAME-1]); failures++; end
    checks++; if (cap_busy[FRAME] !== 1'b1)     begin $display("FAIL t2_busy_gap got=%b exp=1", cap_busy[FRAME]); failures++; end
    checks++; if (cap_busy[2*FRAME] !== 1'b0)   begin $display("FAIL t2_busy_end got=%b exp=0", cap_busy[2*FRAME]); failures++; end
  endtask

  task automatic test_holding_full();
    bit ok;
    int t;
    int acc_n = 0;
    logic [7:0] bytes [3];
    logic [2:0] par;
    logic [7:0] d;
    bytes[0] = 8'h11; bytes[1] = 8'h23; bytes[2] = 8'h7F;
    par = 3'b110;
    fork
      capture(0, 3 * FRAME + 2, ok);
      begin
        @(negedge clk);
        valid_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
          din_w[0] = bytes[k];
          t = 0;
          while (ready_v[0] !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk);
          #1;
        end
        valid_v[0] = 1'b0;
      end
    join
    checks++; if (!ok) begin $display("FAIL t3_capture_timeout got=0 exp=1"); failures++; end
    for (int i = 0; i < 3 * FRAME + 2; i++) if (cap_acc[i] === 1'b1) acc_n++;
    checks++; if (acc_n !== 2) begin $display("FAIL t3_accept_count got=%0d exp=2", acc_n); failures++; end
    checks++; if (cap_acc[0] !== 1'b1)     begin $display("FAIL t3_accept_f1 got=%b exp=1", cap_acc[0]); failures++; end
    checks++; if (cap_acc[FRAME] !== 1'b1) begin $display("FAIL t3_accept_f2 got=%b exp=1", cap_acc[FRAME]); failures++; end
    checks++; if (cap_rdy[50] !== 1'b0)    begin $display("FAIL t3_ready_full1 got=%b exp=0", cap_rdy[50]); failures++; end
    checks++; if (cap_rdy[180] !== 1'b0)   begin $display("FAIL t3_ready_full2 got=%b exp=0", cap_rdy[180]); failures++; end
    checks++; if (cap_rdy[2*FRAME+1] !== 1'b1) begin $display("FAIL t3_ready_empty got=%b exp=1", cap_rdy[2*FRAME+1]); failures++; end
    for (int f = 0; f < 3; f++) begin
      d = decode_at(f * FRAME);
      checks++;
      if (d !== bytes[f]) begin $display("FAIL t3_data%0d got=%h exp=%h", f, d, bytes[f]); failures++; end
      checks++;
      if (cap_tx[f*FRAME + 9*DIV + DIV/2] !== par[f]) begin
        $display("FAIL t3_parity%0d got=%b exp=%b", f, cap_tx[f*FRAME + 9*DIV + DIV/2], par[f]); failures++;
      end
    end
    checks++; if (cap_busy[3*FRAME] !== 1'b0) begin $display("FAIL t3_busy_end got=%b exp=0", cap_busy[3*FRAME]); failures++; end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    int n;
    int bad = 0;
    logic [10:0] exp_f;
    exp_f = 11'b1_0_11000011_0;
    send_byte(0, 8'h5A);
    @(posedge clk);
    #1;
    send_byte(0, 8'h77);
    repeat (44) @(posedge clk);
    #1;
    checks++; if (tx_v[0] !== 1'b1)    begin $display("FAIL t4_data_bit3 got=%b exp=1", tx_v[0]); failures++; end
    checks++; if (ready_v[0] !== 1'b0) begin $display("FAIL t4_held got=%b exp=0", ready_v[0]); failures++; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (tx_v[0] !== 1'b1)    begin $display("FAIL t4_rst_tx got=%b exp=1", tx_v[0]); failures++; end
    checks++; if (busy_v[0] !== 1'b0)  begin $display("FAIL t4_rst_busy got=%b exp=0", busy_v[0]); failures++; end
    checks++; if (ready_v[0] !== 1'b1) begin $display("FAIL t4_rst_ready got=%b exp=1", ready_v[0]); failures++; end
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin $display("FAIL t4_held_byte_lost bad_cycles=%0d exp=0", bad); failures++; end
    send_byte(0, 8'hC3);
    capture(0, FRAME + 2, ok);
    checks++; if (!ok) begin $display("FAIL t4_capture_timeout got=0 exp=1"); failures++; end
    for (int k = 0; k < 11; k++) begin
      n = bad_cycles(k * DIV, DIV, exp_f[k]);
      checks++;
      if (n !== 0) begin $display("FAIL t4_bit%0d bad_cycles=%0d exp=0", k, n); failures++; end
    end
  endtask

  task automatic test_no_parity_two_stop();
    bit ok;
    int n;
    logic [10:0] exp_f;
    exp_f = 11'b11_00111100_0;
    send_byte(1, 8'h3C);
    capture(1, FRAME + 2, ok);
    checks++; if (!ok) begin $display("FAIL t5_capture_timeout got=0 exp=1"); failures++; end
    for (int k = 0; k < 11; k++) begin
      n = bad_cycles(k * DIV, DIV, exp_f[k]);
      checks++;
      if (n !== 0) begin $display("FAIL t5_bit%0d bad_cycles=%0d exp=0", k, n); failures++; end
    end
    checks++; if (cap_done[FRAME-1-DIV] !== 1'b0) begin $display("FAIL t5_done_stop1 got=%b exp=0", cap_done[FRAME-1-DIV]); failures++; end
    checks++; if (cap_done[FRAME-1] !== 1'b1)     begin $display("FAIL t5_done_stop2 got=%b exp=1", cap_done[FRAME-1]); failures++; end
    checks++; if (cap_busy[FRAME] !== 1'b0)       begin $display("FAIL t5_busy_end got=%b exp=0", cap_busy[FRAME]); failures++; end
  endtask

  task automatic test_loopback();
    int rx_cnt = 0, bad_data = 0, bad_fmt = 0, bad_gap = 0;
    int t;
    logic [7:0] d;
    logic [7:0] exp_b;
    fork
      begin
        @(negedge clk);
        valid_v[0] = 1'b1;
        for (int b = 0; b < 256; b++) begin
          din_w[0] = 8'(b);
          t = 0;
          while (ready_v[0] !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk);
          #1;
        end
        valid_v[0] = 1'b0;
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
          t = 0;
          while (tx_v[0] !== 1'b0 && t < TMO) begin
            @(negedge clk);
            t++;
          end
          if (tx_v[0] !== 1'b0) break;
          repeat (DIV / 2) @(negedge clk);
          if (tx_v[0] !== 1'b0) bad_fmt++;
          for (int j = 0; j < 8; j++) begin
            repeat (DIV) @(negedge clk);
            d[j] = tx_v[0];
          end
          repeat (DIV) @(negedge clk);
          if (tx_v[0] !== ^d) bad_fmt++;
          repeat (DIV) @(negedge clk);
          if (tx_v[0] !== 1'b1) bad_fmt++;
          rx_cnt++;
          exp_b = 8'(f);
          if (d !== exp_b) bad_data++;
          repeat (DIV / 2) @(negedge clk);
          if (f < 255 && tx_v[0] !== 1'b0) bad_gap++;
        end
      end
    join
    checks++; if (rx_cnt !== 256)  begin $display("FAIL t6_rx_count got=%0d exp=256", rx_cnt); failures++; end
    checks++; if (bad_data !== 0)  begin $display("FAIL t6_data_errors got=%0d exp=0", bad_data); failures++; end
    checks++; if (bad_fmt !== 0)   begin $display("FAIL t6_frame_errors got=%0d exp=0", bad_fmt); failures++; end
    checks++; if (bad_gap !== 0)   begin $display("FAIL t6_gap_errors got=%0d exp=0", bad_gap); failures++; end
    checks++; if (busy_v[0] !== 1'b0) begin $display("FAIL t6_busy_end got=%b exp=0", busy_v[0]); failures++; end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) din_w[i] = 8'h00;
    valid_v = 3'b000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_holding_full();
    test_mid_frame_reset();
    test_no_parity_two_stop();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog_expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
